// File: rtl/boot_loader.sv
// Boot-time program loader: assembles a length-prefixed little-endian byte stream into 32-bit
// words, writes them to instruction memory and holds the core in BIOS mode until the checksum verifies.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic        mem_cs,
  output logic        on_bios,
  output logic        boot_error,
  output logic [31:0] words_loaded
);

  typedef enum logic [2:0] {HEADER, PAYLOAD, WRITE, CHECK, DONE, ERROR} state_t;

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] n_words;
  logic [31:0] word;
  logic [31:0] index;
  logic [31:0] idle_cnt;
  logic [7:0]  xor_acc;
  logic        started;

  logic        accept;
  logic        last_byte;
  logic        timed_out;
  logic [31:0] shifted_n;
  logic [31:0] shifted_word;
  logic [31:0] index_inc;

  assign rx_ready     = (state == HEADER) || (state == PAYLOAD) || (state == CHECK);
  assign accept       = rx_valid && rx_ready;
  assign last_byte    = (byte_cnt == 2'd3);
  assign shifted_n    = {rx_byte, n_words[31:8]};
  assign shifted_word = {rx_byte, word[31:8]};
  assign index_inc    = index + 32'd1;
  // The idle watchdog only arms once the first header byte has arrived.
  assign timed_out    = started && rx_ready && !accept && ((idle_cnt + 32'd1) >= TIMEOUT_CYCLES);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= HEADER;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HEADER: begin
        if (timed_out) state_next = ERROR;
        else if (accept && last_byte) begin
          if (shifted_n > MAX_WORDS)   state_next = ERROR;
          else if (shifted_n == 32'd0) state_next = CHECK;
          else                         state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (timed_out)                 state_next = ERROR;
        else if (accept && last_byte)  state_next = WRITE;
      end
      WRITE:   state_next = (index_inc == n_words) ? CHECK : PAYLOAD;
      CHECK: begin
        if (timed_out)   state_next = ERROR;
        else if (accept) state_next = (rx_byte == xor_acc) ? DONE : ERROR;
      end
      default: state_next = state;
    endcase
  end

  // Datapath and registered outputs; the write strobe is armed by the 4th word byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt     <= 2'd0;
      n_words      <= 32'd0;
      word         <= 32'd0;
      index        <= 32'd0;
      idle_cnt     <= 32'd0;
      xor_acc      <= 8'd0;
      started      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_data     <= 32'd0;
      mem_cs       <= 1'b0;
      on_bios      <= 1'b1;
      boot_error   <= 1'b0;
      words_loaded <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        idle_cnt <= 32'd0;
        started  <= 1'b1;
      end else if (started && rx_ready) begin
        idle_cnt <= idle_cnt + 32'd1;
      end
      if ((state == HEADER) && accept) n_words <= shifted_n;
      if ((state == PAYLOAD) && accept) begin
        word    <= shifted_word;
        xor_acc <= xor_acc ^ rx_byte;
        if (last_byte) begin
          mem_we   <= 1'b1;
          mem_addr <= BASE_ADDR + index;
          mem_data <= shifted_word;
        end
      end
      if (state == WRITE) begin
        index        <= index_inc;
        words_loaded <= words_loaded + 32'd1;
      end
      if ((state_next == DONE) && (state != DONE)) begin
        on_bios <= 1'b0;
        mem_cs  <= 1'b1;
      end
      if (state_next == ERROR) boot_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected memory writes are queued as bytes are driven
// and compared when mem_we is observed.
module tb_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          MAXW = 1024;
  localparam int          TMO  = 24;

  logic        clock;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        mem_cs;
  logic        on_bios;
  logic        boot_error;
  logic [31:0] words_loaded;

  int          check_count = 0;
  int          fail_count  = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] img_words[0:1];

  boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_cs(mem_cs), .on_bios(on_bios), .boot_error(boot_error), .words_loaded(words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Every observed write strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      if (exp_addr.size() == 0) begin
        checkOutput("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        checkOutput("write_addr", mem_addr, exp_addr.pop_front());
        checkOutput("write_data", mem_data, exp_data.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_byte  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rx_ready) ok = 1'b1;
      @(negedge clock);
    end
    checkOutput("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    reset    = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rst_on_bios", 32'(on_bios), 32'd1);
    checkOutput("rst_mem_cs", 32'(mem_cs), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_boot_error", 32'(boot_error), 32'd0);
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'd1);
    checkOutput("rst_mem_addr", mem_addr, BASE);
    checkOutput("rst_mem_data", mem_data, 32'd0);
    checkOutput("rst_words", words_loaded, 32'd0);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Drives header n, the first payload_bytes of img_words and optionally the checksum (XOR chk_flip).
  task automatic applyStimulus(input int n, input int payload_bytes, input logic [7:0] chk_flip,
                               input int gap, input bit send_chk);
    logic [31:0] nv;
    logic [31:0] w;
    logic [7:0]  chk;
    logic [7:0]  b;
    nv  = 32'(n);
    chk = 8'h00;
    for (int i = 0; i < 4; i++) begin
      send_byte(nv[8*i +: 8]);
      if (gap > 0) begin
        rx_valid = 1'b0;
        repeat (gap) @(negedge clock);
      end
    end
    for (int k = 0; k < payload_bytes; k++) begin
      w   = img_words[k / 4];
      b   = w[8*(k % 4) +: 8];
      chk = chk ^ b;
      if (k % 4 == 3) begin
        exp_addr.push_back(BASE + 32'(k / 4));
        exp_data.push_back(w);
      end
      send_byte(b);
      if (k % 4 == 3) begin
        checkOutput("we_after_4th", 32'(mem_we), 32'd1);
        checkOutput("ready_in_write", 32'(rx_ready), 32'd0);
      end
      if (gap > 0) begin
        rx_valid = 1'b0;
        repeat (gap) @(negedge clock);
      end
    end
    if (send_chk) send_byte(chk ^ chk_flip);
    rx_valid = 1'b0;
  endtask

  task automatic check_final(input string tag, input logic done, input logic [31:0] nw);
    repeat (2) @(negedge clock);
    checkOutput({tag, "_on_bios"}, 32'(on_bios), 32'(!done));
    checkOutput({tag, "_mem_cs"}, 32'(mem_cs), 32'(done));
    checkOutput({tag, "_boot_error"}, 32'(boot_error), 32'(!done));
    checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    checkOutput({tag, "_words"}, words_loaded, nw);
    checkOutput({tag, "_pending"}, 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    img_words[0] = 32'h1234_5678;
    img_words[1] = 32'hDEAD_BEEF;

    $display("[TB] good two-word image, continuous valid");
    do_reset();
    applyStimulus(2, 8, 8'h00, 0, 1'b1);
    check_final("t1", 1'b1, 32'd2);
    checkOutput("t1_hold_addr", mem_addr, BASE + 32'd1);
    checkOutput("t1_hold_data", mem_data, 32'hDEAD_BEEF);

    $display("[TB] bad checksum");
    do_reset();
    applyStimulus(2, 8, 8'h01, 0, 1'b1);
    check_final("t2", 1'b0, 32'd2);

    $display("[TB] empty image");
    do_reset();
    applyStimulus(0, 0, 8'h00, 0, 1'b1);
    check_final("t3", 1'b1, 32'd0);

    $display("[TB] oversize header");
    do_reset();
    applyStimulus(MAXW + 1, 0, 8'h00, 0, 1'b0);
    checkOutput("t4_error_now", 32'(boot_error), 32'd1);
    check_final("t4", 1'b0, 32'd0);

    $display("[TB] gaps just below timeout");
    img_words[0] = 32'hA5A5_5A5A;
    img_words[1] = 32'h0F1E_2D3C;
    do_reset();
    applyStimulus(2, 8, 8'h00, TMO - 1, 1'b1);
    check_final("t5", 1'b1, 32'd2);

    $display("[TB] timeout");
    do_reset();
    repeat (TMO + 4) @(negedge clock);
    checkOutput("t5_no_tmo_idle", 32'(boot_error), 32'd0);
    send_byte(8'h01);
    rx_valid = 1'b0;
    repeat (TMO - 1) @(negedge clock);
    checkOutput("t5_gap_minus1", 32'(boot_error), 32'd0);
    @(negedge clock);
    checkOutput("t5_gap_full", 32'(boot_error), 32'd1);
    checkOutput("t5_tmo_ready", 32'(rx_ready), 32'd0);

    $display("[TB] reset mid-load then reload");
    img_words[0] = 32'h1234_5678;
    img_words[1] = 32'hDEAD_BEEF;
    do_reset();
    applyStimulus(2, 6, 8'h00, 0, 1'b0);
    do_reset();
    applyStimulus(2, 8, 8'h00, 0, 1'b1);
    check_final("t6", 1'b1, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
